// File: rtl/axi_ahb_write_ctrl.sv
// AXI-to-AHB bridge write sequencer: one AXI write burst in, pipelined AHB writes out, one B response back.
// Optional macro AHB_ERROR_ABORT_EN: stop issuing AHB beats after an error response and drain remaining W beats.
module axi_ahb_write_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [3:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  output logic [ADDR_W-1:0] h_addr,
  output logic [1:0]        h_trans,
  output logic              h_write,
  output logic [2:0]        h_size,
  output logic [2:0]        h_burst,
  output logic [DATA_W-1:0] h_wdata,
  input  logic              h_ready,
  input  logic              h_resp
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_LAST_DATA = 3'd2;
  localparam logic [2:0] S_RESP      = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic              fixed_q;
  logic [3:0]        beat_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              data_phase;
  logic              ahb_err;
  logic              len_err;
  logic              size_err;

  logic              abort;
  logic              last_beat;
  logic              w_hs;

`ifdef AHB_ERROR_ABORT_EN
  // An error seen in the current data phase already cancels the pending address phase.
  assign abort = ahb_err | (data_phase & h_resp);
`else
  assign abort = 1'b0;
`endif

  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = w_valid & w_ready;

  always_comb begin
    h_trans = HT_IDLE;
    w_ready = 1'b0;
    case (state)
      S_ADDR: begin
        if (!abort) begin
          if (w_valid)
            h_trans = (beat_cnt == 4'd0 || fixed_q) ? HT_NONSEQ : HT_SEQ;
          else
            h_trans = (beat_cnt == 4'd0) ? HT_IDLE : HT_BUSY;
        end
        w_ready = w_valid & h_ready & h_trans[1];
      end
      S_DRAIN: w_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (len_q == 4'd0 || fixed_q) begin
      h_burst = 3'b000;
    end else begin
      case (len_q)
        4'd3:    h_burst = 3'b011;
        4'd7:    h_burst = 3'b101;
        4'd15:   h_burst = 3'b111;
        default: h_burst = 3'b001;
      endcase
    end
  end

  assign aw_ready = (state == S_IDLE) & ~reset;
  assign b_valid  = (state == S_RESP);
  assign b_resp   = (b_valid && (ahb_err || len_err || size_err)) ? 2'b10 : 2'b00;
  assign h_write  = h_trans[1];
  assign h_addr   = addr_q;
  assign h_size   = size_q;
  assign h_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      fixed_q    <= 1'b0;
      beat_cnt   <= '0;
      wdata_q    <= '0;
      data_phase <= 1'b0;
      ahb_err    <= 1'b0;
      len_err    <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      if (data_phase && h_ready && h_resp)
        ahb_err <= 1'b1;

      if (state == S_ADDR && w_hs)
        data_phase <= 1'b1;
      else if (h_ready)
        data_phase <= 1'b0;

      case (state)
        S_IDLE: begin
          if (aw_valid) begin
            addr_q   <= aw_addr;
            len_q    <= aw_len;
            size_q   <= aw_size;
            fixed_q  <= (aw_burst == 2'b00);
            beat_cnt <= '0;
            if (aw_size > MAX_SIZE) begin
              size_err <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (abort) begin
            state <= S_DRAIN;
          end else if (w_hs) begin
            wdata_q  <= w_data;
            beat_cnt <= beat_cnt + 4'd1;
            if (!fixed_q)
              addr_q <= addr_q + (ADDR_W'(1) << size_q);
            if (w_last != last_beat)
              len_err <= 1'b1;
            if (last_beat)
              state <= S_LAST_DATA;
          end
        end
        S_LAST_DATA: begin
          if (h_ready)
            state <= S_RESP;
        end
        S_RESP: begin
          if (b_ready) begin
            ahb_err  <= 1'b0;
            len_err  <= 1'b0;
            size_err <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (w_last != last_beat)
              len_err <= 1'b1;
            // A data phase still stalled on the bus must finish before the response.
            if (last_beat)
              state <= (data_phase && !h_ready) ? S_LAST_DATA : S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ahb_write_ctrl.sv
// Directed self-checking bench for axi_ahb_write_ctrl (DATA_W=32, ADDR_W=32).
// Expectations follow AHB_ERROR_ABORT_EN when the bench is built with that macro.
module tb_axi_ahb_write_ctrl;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [3:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        w_last;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [2:0]  h_burst;
  logic [31:0] h_wdata;
  logic        h_ready;
  logic        h_resp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_ahb_write_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .h_addr(h_addr), .h_trans(h_trans), .h_write(h_write), .h_size(h_size),
    .h_burst(h_burst), .h_wdata(h_wdata), .h_ready(h_ready), .h_resp(h_resp)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                         input logic [1:0] b);
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b;
    #1;
    check_output("aw_ready", aw_ready, 1);
    @(posedge clk);
    #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] exp_trans,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    @(negedge clk);
    w_valid = 1'b1; w_data = d; w_last = last;
    #1;
    check_output("beat_trans", h_trans, exp_trans);
    check_output("beat_addr", h_addr, exp_addr);
    check_output("beat_wdata", h_wdata, exp_wdata);
    check_output("beat_w_ready", w_ready, 1);
    @(posedge clk);
    #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic drain_beat(input logic last);
    @(negedge clk);
    w_valid = 1'b1; w_last = last;
    #1;
    check_output("drain_w_ready", w_ready, 1);
    check_output("drain_trans", h_trans, T_IDLE);
    @(posedge clk);
    #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic wait_resp(input logic [1:0] exp_resp);
    @(negedge clk);
    b_ready = 1'b1;
    #1;
    check_output("b_valid", b_valid, 1);
    check_output("b_resp", b_resp, exp_resp);
    check_output("resp_aw_ready", aw_ready, 0);
    @(posedge clk);
    #1;
    b_ready = 1'b0;
  endtask

  task automatic finish_burst(input logic [1:0] exp_resp, input logic [31:0] exp_wdata);
    @(negedge clk);
    #1;
    check_output("last_data_trans", h_trans, T_IDLE);
    check_output("last_data_b_valid", b_valid, 0);
    check_output("last_data_wdata", h_wdata, exp_wdata);
    wait_resp(exp_resp);
  endtask

  initial begin
    reset = 1'b1; aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 1'b0; w_data = '0; w_last = 1'b0; b_ready = 1'b0; h_ready = 1'b1; h_resp = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_aw_ready", aw_ready, 0);
    check_output("rst_w_ready", w_ready, 0);
    check_output("rst_b_valid", b_valid, 0);
    check_output("rst_b_resp", b_resp, 0);
    check_output("rst_h_trans", h_trans, T_IDLE);
    check_output("rst_h_write", h_write, 0);
    check_output("rst_h_addr", h_addr, 0);
    check_output("rst_h_size", h_size, 0);
    check_output("rst_h_burst", h_burst, 0);
    check_output("rst_h_wdata", h_wdata, 0);
    reset = 1'b0;
    #1;
    check_output("post_rst_aw_ready", aw_ready, 1);

    // Basic INCR4 burst
    send_aw(32'h1000, 4'd3, 3'd2, 2'b01);
    check_output("incr4_h_burst", h_burst, 3'b011);
    check_output("incr4_h_size", h_size, 3'd2);
    send_beat(32'hD0, 1'b0, T_NONSEQ, 32'h1000, 32'h0);
    send_beat(32'hD1, 1'b0, T_SEQ, 32'h1004, 32'hD0);
    send_beat(32'hD2, 1'b0, T_SEQ, 32'h1008, 32'hD1);
    send_beat(32'hD3, 1'b1, T_SEQ, 32'h100C, 32'hD2);
    finish_burst(2'b00, 32'hD3);

    // Address wrap at the top of the address space
    send_aw(32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01);
    check_output("wrap_h_burst", h_burst, 3'b001);
    send_beat(32'hE0, 1'b0, T_NONSEQ, 32'hFFFF_FFFC, 32'hD3);
    send_beat(32'hE1, 1'b1, T_SEQ, 32'h0000_0000, 32'hE0);
    finish_burst(2'b00, 32'hE1);

    // W gap then AHB wait states
    send_aw(32'h2000, 4'd3, 3'd2, 2'b11);
    send_beat(32'hF0, 1'b0, T_NONSEQ, 32'h2000, 32'hE1);
    send_beat(32'hF1, 1'b0, T_SEQ, 32'h2004, 32'hF0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_output("gap_trans", h_trans, T_BUSY);
      check_output("gap_addr", h_addr, 32'h2008);
      check_output("gap_w_ready", w_ready, 0);
    end
    send_beat(32'hF2, 1'b0, T_SEQ, 32'h2008, 32'hF1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      h_ready = 1'b0; w_valid = 1'b1; w_data = 32'hF3; w_last = 1'b1;
      #1;
      check_output("wait_trans", h_trans, T_SEQ);
      check_output("wait_addr", h_addr, 32'h200C);
      check_output("wait_wdata", h_wdata, 32'hF2);
      check_output("wait_w_ready", w_ready, 0);
    end
    @(posedge clk);
    #1;
    h_ready = 1'b1;
    send_beat(32'hF3, 1'b1, T_SEQ, 32'h200C, 32'hF2);
    finish_burst(2'b00, 32'hF3);

    // Early w_last
    send_aw(32'h3000, 4'd3, 3'd2, 2'b01);
    send_beat(32'h10, 1'b0, T_NONSEQ, 32'h3000, 32'hF3);
    send_beat(32'h11, 1'b1, T_SEQ, 32'h3004, 32'h10);
    send_beat(32'h12, 1'b0, T_SEQ, 32'h3008, 32'h11);
    send_beat(32'h13, 1'b1, T_SEQ, 32'h300C, 32'h12);
    finish_burst(2'b10, 32'h13);

    // Missing w_last
    send_aw(32'h4000, 4'd3, 3'd2, 2'b01);
    send_beat(32'h20, 1'b0, T_NONSEQ, 32'h4000, 32'h13);
    send_beat(32'h21, 1'b0, T_SEQ, 32'h4004, 32'h20);
    send_beat(32'h22, 1'b0, T_SEQ, 32'h4008, 32'h21);
    send_beat(32'h23, 1'b0, T_SEQ, 32'h400C, 32'h22);
    finish_burst(2'b10, 32'h23);

    // AHB error response on beat 0 of an INCR8 burst
    send_aw(32'h5000, 4'd7, 3'd2, 2'b01);
    check_output("incr8_h_burst", h_burst, 3'b101);
    send_beat(32'h30, 1'b0, T_NONSEQ, 32'h5000, 32'h23);
    h_resp = 1'b1;
`ifdef AHB_ERROR_ABORT_EN
    @(negedge clk);
    w_valid = 1'b1; w_data = 32'h31;
    #1;
    check_output("abort_trans", h_trans, T_IDLE);
    check_output("abort_w_ready", w_ready, 0);
    @(posedge clk);
    #1;
    h_resp = 1'b0; w_valid = 1'b0;
    for (int i = 1; i <= 7; i++)
      drain_beat(i == 7);
    wait_resp(2'b10);
`else
    send_beat(32'h31, 1'b0, T_SEQ, 32'h5004, 32'h30);
    h_resp = 1'b0;
    for (int i = 2; i <= 7; i++)
      send_beat(32'h30 + 32'(i), i == 7, T_SEQ, 32'h5000 + 32'(4 * i), 32'h30 + 32'(i - 1));
    finish_burst(2'b10, 32'h37);
`endif

    // FIXED burst, also proves error flags were cleared
    send_aw(32'h6000, 4'd1, 3'd2, 2'b00);
    check_output("fixed_h_burst", h_burst, 3'b000);
    send_beat(32'h40, 1'b0, T_NONSEQ, 32'h6000, h_wdata);
    send_beat(32'h41, 1'b1, T_NONSEQ, 32'h6000, 32'h40);
    finish_burst(2'b00, 32'h41);

    // Oversize beat for a 32-bit bus
    send_aw(32'h7000, 4'd1, 3'd3, 2'b01);
    drain_beat(1'b0);
    drain_beat(1'b1);
    wait_resp(2'b10);

    // Reset in the middle of a burst
    send_aw(32'h8000, 4'd3, 3'd2, 2'b01);
    send_beat(32'h50, 1'b0, T_NONSEQ, 32'h8000, 32'h41);
    send_beat(32'h51, 1'b0, T_SEQ, 32'h8004, 32'h50);
    @(negedge clk);
    w_valid = 1'b1; w_data = 32'h52; reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("midrst_h_trans", h_trans, T_IDLE);
    check_output("midrst_w_ready", w_ready, 0);
    check_output("midrst_b_valid", b_valid, 0);
    check_output("midrst_aw_ready", aw_ready, 0);
    reset = 1'b0; w_valid = 1'b0;
    #1;
    check_output("midrst_post_aw_ready", aw_ready, 1);
    send_aw(32'h9000, 4'd0, 3'd2, 2'b01);
    check_output("single_h_burst", h_burst, 3'b000);
    send_beat(32'h60, 1'b1, T_NONSEQ, 32'h9000, 32'h0);
    finish_burst(2'b00, 32'h60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
